// File: rtl/si_pkg.sv
// Shared screen/coordinate definitions for the shooter sprites, plus small
// elaboration-time helpers used by the bullet controller.
package si_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int SPAWN_Y_DEF     = 440;
  localparam int BULLET_STEP_DEF = 4;

  // Index width for an n-entry table; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One player-bullet slot: live flag and X/Y position, with hit > spawn > move
// priority and retirement once the bullet would leave the top of the screen.
module bullet_slot
  import si_pkg::*;
#(
  parameter int BULLET_STEP = BULLET_STEP_DEF,
  parameter int SPAWN_Y     = SPAWN_Y_DEF
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   spawn,
  input  logic   move,
  input  logic   hit,
  input  coord_t spawn_x,
  output logic   active,
  output coord_t x,
  output coord_t y
);

  localparam coord_t STEP    = coord_t'(BULLET_STEP);
  localparam coord_t START_Y = coord_t'(SPAWN_Y);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (hit) begin
      active <= 1'b0;
    end else if (spawn) begin
      active <= 1'b1;
      x      <= spawn_x;
      y      <= START_Y;
    end else if (move && active) begin
      // Retire instead of subtracting so the unsigned Y never wraps.
      if (y < STEP) begin
        active <= 1'b0;
      end else begin
        y <= y - STEP;
      end
    end
  end

endmodule

// File: rtl/player_bullet_ctrl.sv
// Player bullet controller: turns fire edges into bullet spawns (with cooldown
// and slot-full refusal), advances bullets per frame and retires them on hits.
module player_bullet_ctrl
  import si_pkg::*;
#(
  parameter int MAX_BULLETS     = 4,
  parameter int BULLET_STEP     = BULLET_STEP_DEF,
  parameter int SPAWN_Y         = SPAWN_Y_DEF,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             frame_tick,
  input  logic                             shoot_bullet,
  input  coord_t                           player_X,
  input  logic                             hit_valid,
  input  logic [idx_w(MAX_BULLETS)-1:0]    hit_idx,
  output logic [MAX_BULLETS-1:0]           bullet_active,
  output logic [MAX_BULLETS*COORD_W-1:0]   bullet_x,
  output logic [MAX_BULLETS*COORD_W-1:0]   bullet_y,
  output logic [3:0]                       bullet_count,
  output logic                             fire_denied
);

  localparam int IDX_W = idx_w(MAX_BULLETS);
  localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 1);

  logic                   shoot_q;
  logic                   fire;
  logic [CD_W-1:0]        cooldown;
  logic                   cd_zero;
  logic                   any_free;
  logic                   do_spawn;
  logic [MAX_BULLETS-1:0] free_oh;
  logic [MAX_BULLETS-1:0] spawn_vec;
  logic [MAX_BULLETS-1:0] hit_vec;

  assign fire     = shoot_bullet & ~shoot_q;
  assign cd_zero  = (cooldown == '0);
  assign any_free = ~&bullet_active;
  assign do_spawn = fire & cd_zero & any_free;

  // Lowest clear bit of bullet_active, as a one-hot.
  assign free_oh   = ~bullet_active & (bullet_active + 1'b1);
  assign spawn_vec = do_spawn ? free_oh : '0;

  // Hits on idle slots or out-of-range indices decode to nothing.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (hit_valid && (hit_idx == IDX_W'(i))) begin
        hit_vec[i] = bullet_active[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shoot_q     <= 1'b0;
      cooldown    <= '0;
      fire_denied <= 1'b0;
    end else begin
      shoot_q     <= shoot_bullet;
      fire_denied <= fire & ~do_spawn;
      if (do_spawn) begin
        cooldown <= CD_W'(COOLDOWN_FRAMES);
      end else if (frame_tick && !cd_zero) begin
        cooldown <= cooldown - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .BULLET_STEP (BULLET_STEP),
      .SPAWN_Y     (SPAWN_Y)
    ) u_slot (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .spawn   (spawn_vec[g]),
      .move    (frame_tick),
      .hit     (hit_vec[g]),
      .spawn_x (player_X),
      .active  (bullet_active[g]),
      .x       (bullet_x[COORD_W*g +: COORD_W]),
      .y       (bullet_y[COORD_W*g +: COORD_W])
    );
  end

  always_comb begin
    bullet_count = '0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      bullet_count = bullet_count + {3'b000, bullet_active[i]};
    end
  end

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Bench for player_bullet_ctrl: directed scenarios with literal expectations,
// then random traffic compared every cycle against a slot-array model.
module tb_player_bullet_ctrl;

  localparam int N  = 4;
  localparam int CD = 8;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick;
  logic        shoot_bullet;
  logic [9:0]  player_X;
  logic        hit_valid;
  logic [1:0]  hit_idx;
  logic [N-1:0]    bullet_active;
  logic [N*10-1:0] bullet_x;
  logic [N*10-1:0] bullet_y;
  logic [3:0]  bullet_count;
  logic        fire_denied;

  int vectors = 0;
  int errors  = 0;

  int m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_cd, m_sq, m_den;

  player_bullet_ctrl dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .shoot_bullet  (shoot_bullet),
    .player_X      (player_X),
    .hit_valid     (hit_valid),
    .hit_idx       (hit_idx),
    .bullet_active (bullet_active),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_count  (bullet_count),
    .fire_denied   (fire_denied)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cd = 0; m_sq = 0; m_den = 0;
  endtask

  task automatic model_edge();
    int fire, free, spawn, hs;
    fire = (shoot_bullet && m_sq == 0) ? 1 : 0;
    free = -1;
    for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) free = i;
    spawn = (fire == 1 && m_cd == 0 && free >= 0) ? 1 : 0;
    hs = -1;
    if (hit_valid && int'(hit_idx) < N && m_act[hit_idx] == 1) hs = int'(hit_idx);
    for (int i = 0; i < N; i++) begin
      if (i == hs) begin
        m_act[i] = 0;
      end else if (spawn == 1 && i == free) begin
        m_act[i] = 1; m_x[i] = int'(player_X); m_y[i] = 440;
      end else if (frame_tick && m_act[i] == 1) begin
        if (m_y[i] < 4) m_act[i] = 0;
        else m_y[i] = m_y[i] - 4;
      end
    end
    if (spawn == 1) m_cd = CD;
    else if (frame_tick && m_cd > 0) m_cd = m_cd - 1;
    m_den = (fire == 1 && spawn == 0) ? 1 : 0;
    m_sq  = shoot_bullet ? 1 : 0;
  endtask

  task automatic compare();
    int cnt;
    int ea;
    cnt = 0; ea = 0;
    for (int i = 0; i < N; i++) begin
      cnt += m_act[i];
      ea  |= m_act[i] << i;
    end
    chk("active", int'(bullet_active), ea);
    chk("count", int'(bullet_count), cnt);
    chk("denied", int'(fire_denied), m_den);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("x[%0d]", i), int'(bullet_x[10*i +: 10]), m_x[i]);
      chk($sformatf("y[%0d]", i), int'(bullet_y[10*i +: 10]), m_y[i]);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    if (!Reset_n) model_reset();
    else model_edge();
    @(negedge Clk);
    compare();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; step();
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; shoot_bullet = 1'b0;
    player_X = '0; hit_valid = 1'b0; hit_idx = '0;
    model_reset();
    #3;
    chk("rst_active", int'(bullet_active), 0);
    chk("rst_count", int'(bullet_count), 0);
    chk("rst_denied", int'(fire_denied), 0);
    step();
    Reset_n = 1'b1;
    step();

    // Held fire level spawns once; bullet climbs 4 px per frame.
    player_X = 10'd320; shoot_bullet = 1'b1; step();
    chk("t2_x0", int'(bullet_x[9:0]), 320);
    chk("t2_y0", int'(bullet_y[9:0]), 440);
    for (int k = 0; k < 20; k++) begin
      ticks(1);
      if (k == 9) chk("t2_y0_10ticks", int'(bullet_y[9:0]), 400);
    end
    chk("t2_single_spawn", int'(bullet_count), 1);
    shoot_bullet = 1'b0; step();

    // Cooldown refusal, then spawn into slot 1 once it expires.
    do_reset();
    shoot_bullet = 1'b1; step(); shoot_bullet = 1'b0; step();
    ticks(3);
    shoot_bullet = 1'b1; step();
    chk("t3_denied", int'(fire_denied), 1);
    shoot_bullet = 1'b0; step();
    chk("t3_denied_pulse", int'(fire_denied), 0);
    ticks(6);
    shoot_bullet = 1'b1; step();
    chk("t3_slot1", int'(bullet_active), 4'b0011);
    shoot_bullet = 1'b0; step();

    // Fill every slot, then a further fire is refused as full.
    for (int k = 0; k < 2; k++) begin
      ticks(8);
      shoot_bullet = 1'b1; step(); shoot_bullet = 1'b0; step();
    end
    chk("t4_full", int'(bullet_count), 4);
    ticks(8);
    shoot_bullet = 1'b1; step();
    chk("t4_denied", int'(fire_denied), 1);
    chk("t4_count", int'(bullet_count), 4);
    shoot_bullet = 1'b0; step();

    // Asynchronous reset clears live bullets without a clock edge.
    #2 Reset_n = 1'b0;
    #1;
    chk("t1_async_active", int'(bullet_active), 0);
    chk("t1_async_count", int'(bullet_count), 0);
    model_reset();
    step();
    Reset_n = 1'b1;
    step();

    // Climb to the top edge and retire.
    player_X = 10'd50; shoot_bullet = 1'b1; step(); shoot_bullet = 1'b0; step();
    ticks(110);
    chk("t5_y_top", int'(bullet_y[9:0]), 0);
    chk("t5_alive", int'(bullet_active[0]), 1);
    ticks(1);
    chk("t5_retired", int'(bullet_active[0]), 0);
    chk("t5_count", int'(bullet_count), 0);

    // Hit, frame tick and fire on the same cycle.
    do_reset();
    player_X = 10'd100; shoot_bullet = 1'b1; step(); shoot_bullet = 1'b0; step();
    ticks(8);
    player_X = 10'd200; hit_valid = 1'b1; hit_idx = 2'd0;
    frame_tick = 1'b1; shoot_bullet = 1'b1; step();
    chk("t6_slot0_cleared", int'(bullet_active[0]), 0);
    chk("t6_slot1_spawn", int'(bullet_active[1]), 1);
    chk("t6_slot1_x", int'(bullet_x[19:10]), 200);
    chk("t6_slot1_y", int'(bullet_y[19:10]), 440);
    hit_valid = 1'b0; frame_tick = 1'b0; shoot_bullet = 1'b0; step();
    ticks(8);
    player_X = 10'd300; shoot_bullet = 1'b1; step();
    chk("t6_reuse_slot0", int'(bullet_active[0]), 1);
    chk("t6_reuse_x", int'(bullet_x[9:0]), 300);
    shoot_bullet = 1'b0; step();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) shoot_bullet = ~shoot_bullet;
      hit_valid = ($urandom_range(0, 4) == 0);
      hit_idx   = 2'($urandom_range(0, 3));
      player_X  = 10'($urandom_range(0, 639));
      Reset_n   = ($urandom_range(0, 599) != 0);
      step();
      Reset_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
